// File: rtl/if_fetch.sv
// Instruction fetch front-end: issues 64-bit i-cache lookups, buffers fetch groups, feeds decode one word per cycle.
// Define IF_FETCH_FAULT_EN to record bus errors per group and stall fetch after a faulting group until a redirect.
module if_fetch #(
    parameter logic [31:0] BOOT_ADDR  = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_request_i,
    input  logic [31:0] branch_pc_i,
    input  logic        fence_i_i,
    output logic        icache_rd_o,
    output logic [31:0] icache_pc_o,
    output logic        icache_flush_o,
    output logic        icache_invalidate_o,
    input  logic        icache_accept_i,
    input  logic        icache_valid_i,
    input  logic        icache_error_i,
    input  logic [63:0] icache_inst_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic        fetch_fault_o,
    input  logic        fetch_accept_i
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW+1:0] DEPTH_C = (AW+2)'(FIFO_DEPTH);

    logic [28:0]   pc_r;
    logic          skip_r;
    logic          pend_r;
    logic          drop_r;
    logic          stall_r;
    logic          word_r;
    logic          flush_r;
    logic [28:0]   req_pc_r;
    logic          req_skip_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;

    logic [63:0]   fifo_inst_r  [FIFO_DEPTH];
    logic [28:0]   fifo_pc_r    [FIFO_DEPTH];
    logic          fifo_start_r [FIFO_DEPTH];

    logic [AW+1:0] occ_s;
    logic          accept_s;
    logic          resp_s;
    logic          push_s;
    logic          pop_s;
    logic          consume_s;
    logic          word_sel_s;
    logic          unused_s;

    // Outstanding request counts as an occupied slot so a response always has room.
    assign occ_s       = {1'b0, count_r} + (AW+2)'(pend_r);
    assign icache_rd_o = !rst_i && !branch_request_i && !stall_r && !flush_r &&
                         (!pend_r || icache_valid_i) && (occ_s < DEPTH_C);
    assign icache_pc_o         = {pc_r, 3'b000};
    assign icache_flush_o      = flush_r;
    assign icache_invalidate_o = 1'b0;

    assign accept_s  = icache_rd_o && icache_accept_i;
    assign resp_s    = icache_valid_i && pend_r;
    assign push_s    = resp_s && !drop_r && !branch_request_i;
    assign word_sel_s = word_r | fifo_start_r[rd_ptr_r];

    assign fetch_valid_o = (count_r != {(AW+1){1'b0}});
    assign fetch_instr_o = word_sel_s ? fifo_inst_r[rd_ptr_r][63:32] : fifo_inst_r[rd_ptr_r][31:0];
    assign fetch_pc_o    = {fifo_pc_r[rd_ptr_r], word_sel_s, 2'b00};
    assign consume_s     = fetch_accept_i && fetch_valid_o;
    assign pop_s         = consume_s && word_sel_s;

`ifdef IF_FETCH_FAULT_EN
    logic fifo_fault_r [FIFO_DEPTH];
    assign fetch_fault_o = fifo_fault_r[rd_ptr_r] && fetch_valid_o;
    assign unused_s      = ^branch_pc_i[1:0];

    // Fault bit travels with its fetch group.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_fault_r[wr_ptr_r] <= icache_error_i;
        end
    end
`else
    assign fetch_fault_o = 1'b0;
    assign unused_s      = ^{branch_pc_i[1:0], icache_error_i};
`endif

    // Fetch-group payload storage; contents are qualified by count_r so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_inst_r[wr_ptr_r]  <= icache_inst_i;
            fifo_pc_r[wr_ptr_r]    <= req_pc_r;
            fifo_start_r[wr_ptr_r] <= req_skip_r;
        end
    end

    // fence.i becomes a single-cycle registered flush pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flush_r <= 1'b0;
        end else begin
            flush_r <= fence_i_i;
        end
    end

    // Fetch control: PC sequencing, request tracking, redirect and FIFO bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_r       <= BOOT_ADDR[31:3];
            skip_r     <= BOOT_ADDR[2];
            pend_r     <= 1'b0;
            drop_r     <= 1'b0;
            stall_r    <= 1'b0;
            word_r     <= 1'b0;
            req_pc_r   <= BOOT_ADDR[31:3];
            req_skip_r <= 1'b0;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
        end else if (branch_request_i) begin
            pc_r     <= branch_pc_i[31:3];
            skip_r   <= branch_pc_i[2];
            pend_r   <= pend_r && !icache_valid_i;
            drop_r   <= pend_r && !icache_valid_i;
            stall_r  <= 1'b0;
            word_r   <= 1'b0;
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (accept_s) begin
                pend_r     <= 1'b1;
                pc_r       <= pc_r + 29'd1;
                skip_r     <= 1'b0;
                req_pc_r   <= pc_r;
                req_skip_r <= skip_r;
            end else if (resp_s) begin
                pend_r <= 1'b0;
            end
            if (resp_s) begin
                drop_r <= 1'b0;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
`ifdef IF_FETCH_FAULT_EN
                if (icache_error_i) begin
                    stall_r <= 1'b1;
                end
`endif
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            if (consume_s) begin
                word_r <= !word_sel_s;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1'b1);
                2'b01:   count_r <= count_r - (AW+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// Randomized scoreboard bench for if_fetch: expected instruction stream comes from the architectural PC sequence.
module tb_if_fetch;
    localparam logic [31:0] BOOT   = 32'h8000_0000;
    localparam logic [31:0] NO_ERR = 32'hFFFF_FFF8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        branch_request_i;
    logic [31:0] branch_pc_i;
    logic        fence_i_i;
    logic        icache_rd_o;
    logic [31:0] icache_pc_o;
    logic        icache_flush_o;
    logic        icache_invalidate_o;
    logic        icache_accept_i;
    logic        icache_valid_i;
    logic        icache_error_i;
    logic [63:0] icache_inst_i;
    logic        fetch_valid_o;
    logic [31:0] fetch_instr_o;
    logic [31:0] fetch_pc_o;
    logic        fetch_fault_o;
    logic        fetch_accept_i;

    always #5 clk_i = ~clk_i;

    if_fetch #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .branch_request_i(branch_request_i), .branch_pc_i(branch_pc_i), .fence_i_i(fence_i_i),
        .icache_rd_o(icache_rd_o), .icache_pc_o(icache_pc_o), .icache_flush_o(icache_flush_o),
        .icache_invalidate_o(icache_invalidate_o), .icache_accept_i(icache_accept_i),
        .icache_valid_i(icache_valid_i), .icache_error_i(icache_error_i), .icache_inst_i(icache_inst_i),
        .fetch_valid_o(fetch_valid_o), .fetch_instr_o(fetch_instr_o), .fetch_pc_o(fetch_pc_o),
        .fetch_fault_o(fetch_fault_o), .fetch_accept_i(fetch_accept_i)
    );

    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] next_exp_pc;
    logic [31:0] acc_log[$];
    int          vectors = 0;
    int          errors = 0;

    logic        cq_busy;
    logic [31:0] cq_addr;
    int          cq_wait;
    int          lat, acc_pct, dec_pct;
    logic        acc_en, dec_en;
    logic [31:0] err_group;
    int          flush_cnt, flush_rd_cnt, rd_cnt;
    logic        r_br, r_fen;
    logic [31:0] r_tgt;

    // Memory image: every word address maps to a distinct instruction word.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 64) begin
            exp_q.push_back({next_exp_pc, word_at(next_exp_pc)});
            next_exp_pc = next_exp_pc + 32'd4;
        end
    endtask

    task automatic restart_exp(input logic [31:0] pc);
        exp_q.delete();
        next_exp_pc = pc & 32'hFFFF_FFFC;
        refill();
    endtask

    task automatic capture();
        if (icache_flush_o) begin
            flush_cnt++;
            if (icache_rd_o) flush_rd_cnt++;
        end
        if (icache_rd_o) rd_cnt++;
        if (!rst_i && icache_rd_o && icache_accept_i) begin
            chk("icache_pc_align", {29'd0, icache_pc_o[2:0]}, 32'd0);
            acc_log.push_back(icache_pc_o);
            cq_busy = 1'b1;
            cq_addr = icache_pc_o;
            cq_wait = lat;
        end
    endtask

    // One clock cycle: drive inputs after the edge, then record any handshake that will complete.
    task automatic cyc(input logic br, input logic [31:0] tgt, input logic fen);
        @(posedge clk_i);
        #1;
        branch_request_i = br;
        branch_pc_i      = tgt;
        fence_i_i        = fen;
        if (br) restart_exp(tgt);
        refill();
        icache_valid_i = 1'b0;
        icache_error_i = 1'b0;
        if (cq_busy) begin
            if (cq_wait <= 1) begin
                icache_valid_i = 1'b1;
                icache_inst_i  = {word_at(cq_addr + 32'd4), word_at(cq_addr)};
`ifdef IF_FETCH_FAULT_EN
                icache_error_i = (cq_addr == err_group);
`else
                icache_error_i = ($urandom_range(0, 4) == 0);
`endif
                cq_busy = 1'b0;
            end else begin
                cq_wait--;
            end
        end
        icache_accept_i = acc_en && ($urandom_range(0, 99) < acc_pct);
        fetch_accept_i  = dec_en && ($urandom_range(0, 99) < dec_pct);
        #1;
        capture();
    endtask

    // Monitor: every instruction decode consumes must be the next one in the expected stream.
    always @(negedge clk_i) begin
        exp_t e;
        logic exp_fault;
        if (!rst_i && fetch_valid_o && fetch_accept_i && !branch_request_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_delivery", fetch_pc_o, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
`ifdef IF_FETCH_FAULT_EN
                exp_fault = ((e.pc & 32'hFFFF_FFF8) == err_group);
`else
                exp_fault = 1'b0;
`endif
                chk("fetch_pc", fetch_pc_o, e.pc);
                chk("fetch_instr", fetch_instr_o, e.instr);
                chk("fetch_fault", {31'd0, fetch_fault_o}, {31'd0, exp_fault});
            end
        end
    end

    initial begin
        rst_i = 1'b1; branch_request_i = 1'b0; branch_pc_i = 32'd0; fence_i_i = 1'b0;
        icache_accept_i = 1'b0; icache_valid_i = 1'b0; icache_error_i = 1'b0; icache_inst_i = 64'd0;
        fetch_accept_i = 1'b0;
        cq_busy = 1'b0; cq_addr = 32'd0; cq_wait = 0;
        lat = 1; acc_pct = 100; dec_pct = 100; acc_en = 1'b1; dec_en = 1'b1;
        err_group = NO_ERR; flush_cnt = 0; flush_rd_cnt = 0; rd_cnt = 0;
        restart_exp(BOOT);

        // Reset state and boot sequence
        repeat (3) cyc(1'b0, 32'd0, 1'b0);
        #1;
        chk("reset_fetch_valid", {31'd0, fetch_valid_o}, 32'd0);
        chk("reset_rd", {31'd0, icache_rd_o}, 32'd0);
        chk("reset_flush", {31'd0, icache_flush_o}, 32'd0);
        chk("reset_fault", {31'd0, fetch_fault_o}, 32'd0);
        chk("invalidate_tied", {31'd0, icache_invalidate_o}, 32'd0);
        acc_log.delete();
        rst_i = 1'b0;
        #1;
        chk("rd_after_reset", {31'd0, icache_rd_o}, 32'd1);
        chk("pc_after_reset", icache_pc_o, BOOT);
        capture();
        repeat (30) cyc(1'b0, 32'd0, 1'b0);
        if (acc_log.size() < 2) chk("boot_accepts", acc_log.size(), 32'd2);
        else begin
            chk("boot_pc0", acc_log[0], BOOT);
            chk("boot_pc1", acc_log[1], BOOT + 32'd8);
        end

        // Redirect into the upper word of a group
        acc_log.delete();
        cyc(1'b1, 32'h8000_0104, 1'b0);
        repeat (20) cyc(1'b0, 32'd0, 1'b0);
        chk("redir_pc", (acc_log.size() > 0) ? acc_log[0] : 32'd0, 32'h8000_0100);

        // Redirect while a slow refill is outstanding
        lat = 12;
        for (int i = 0; i < 40 && !(cq_busy && cq_wait > 6); i++) cyc(1'b0, 32'd0, 1'b0);
        chk("late_pending", {31'd0, cq_busy}, 32'd1);
        cyc(1'b0, 32'd0, 1'b0);
        cyc(1'b1, 32'h8000_0200, 1'b0);
        acc_log.delete();
        lat = 1;
        repeat (40) cyc(1'b0, 32'd0, 1'b0);
        chk("late_redir_pc", (acc_log.size() > 0) ? acc_log[0] : 32'd0, 32'h8000_0200);

        // Decode stalled: FIFO fills and throttles issue
        dec_en = 1'b0;
        acc_log.delete();
        cyc(1'b1, 32'h8000_0300, 1'b0);
        repeat (30) cyc(1'b0, 32'd0, 1'b0);
        chk("throttle_accepts", acc_log.size(), 32'd4);
        chk("throttle_last", (acc_log.size() > 3) ? acc_log[3] : 32'd0, 32'h8000_0318);
        chk("throttle_rd_low", {31'd0, icache_rd_o}, 32'd0);
        dec_en = 1'b1;
        repeat (40) cyc(1'b0, 32'd0, 1'b0);

        // fence.i with a request pending
        lat = 3;
        for (int i = 0; i < 20 && !(cq_busy && cq_wait == 3); i++) cyc(1'b0, 32'd0, 1'b0);
        chk("fence_pending", {31'd0, cq_busy}, 32'd1);
        flush_cnt = 0; flush_rd_cnt = 0;
        cyc(1'b0, 32'd0, 1'b1);
        repeat (10) cyc(1'b0, 32'd0, 1'b0);
        chk("flush_cycles", flush_cnt, 32'd1);
        chk("flush_no_rd", flush_rd_cnt, 32'd0);
        lat = 1;
        repeat (30) cyc(1'b0, 32'd0, 1'b0);

        // Randomized traffic
        acc_pct = 60; dec_pct = 70;
        for (int i = 0; i < 2000; i++) begin
            lat   = $urandom_range(1, 4);
            r_br  = ($urandom_range(0, 99) < 3);
            r_tgt = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
            r_fen = ($urandom_range(0, 99) < 2);
            cyc(r_br, r_tgt, r_fen);
        end

        // Reset mid-refill; stale response must be ignored
        acc_pct = 100; dec_pct = 100; lat = 6;
        for (int i = 0; i < 40 && !(cq_busy && cq_wait == 6); i++) cyc(1'b0, 32'd0, 1'b0);
        chk("reset_refill_pending", {31'd0, cq_busy}, 32'd1);
        rst_i = 1'b1;
        acc_en = 1'b0;
        #1;
        chk("midreset_valid", {31'd0, fetch_valid_o}, 32'd0);
        chk("midreset_rd", {31'd0, icache_rd_o}, 32'd0);
        repeat (2) cyc(1'b0, 32'd0, 1'b0);
        restart_exp(BOOT);
        acc_log.delete();
        rst_i = 1'b0;
        for (int i = 0; i < 20 && cq_busy; i++) cyc(1'b0, 32'd0, 1'b0);
        cyc(1'b0, 32'd0, 1'b0);
        chk("stale_not_delivered", {31'd0, fetch_valid_o}, 32'd0);
        acc_en = 1'b1; lat = 1;
        repeat (30) cyc(1'b0, 32'd0, 1'b0);
        chk("post_reset_pc", (acc_log.size() > 0) ? acc_log[0] : 32'd0, BOOT);

`ifdef IF_FETCH_FAULT_EN
        // Faulting group stalls fetch until a redirect
        err_group = 32'h8000_0010;
        cyc(1'b1, BOOT, 1'b0);
        repeat (12) cyc(1'b0, 32'd0, 1'b0);
        rd_cnt = 0;
        repeat (20) cyc(1'b0, 32'd0, 1'b0);
        chk("fault_stall_rd", rd_cnt, 32'd0);
        err_group = NO_ERR;
        cyc(1'b1, 32'h8000_0040, 1'b0);
        rd_cnt = 0;
        repeat (10) cyc(1'b0, 32'd0, 1'b0);
        chk("fault_resume", {31'd0, (rd_cnt != 0)}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch front-end sitting directly upstream of the instruction cache. Generates the fetch PC, issues 64-bit aligned lookups on the cache request handshake, and buffers the returned 64-bit fetch groups in a small FIFO. Delivers one 32-bit instruction per cycle to decode. Handles branch redirects, discarding any in-flight cache response, and forwards fence.i as a cache flush.

## Interface
Parameters:
- BOOT_ADDR, 32'h8000_0000: reset PC; bits [1:0] must be zero.
- FIFO_DEPTH, 4: fetch-group entries; power of two, 2..16.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- branch_request_i  in  1  redirect strobe.
- branch_pc_i  in  32  redirect target; bits [1:0] ignored.
- fence_i_i  in  1  fence.i strobe.
- icache_rd_o  out  1  lookup request.
- icache_pc_o  out  32  lookup address; bits [2:0] always 0.
- icache_flush_o  out  1  flush request, one-cycle pulse.
- icache_invalidate_o  out  1  tied 0.
- icache_accept_i  in  1  cache accepts request.
- icache_valid_i  in  1  response valid, one cycle.
- icache_error_i  in  1  bus error flag for the response.
- icache_inst_i  in  64  fetch group; [31:0] is the word at PC+0, [63:32] is the word at PC+4.
- fetch_valid_o  out  1  instruction valid to decode.
- fetch_instr_o  out  32  instruction.
- fetch_pc_o  out  32  instruction PC.
- fetch_fault_o  out  1  fetch bus error on this instruction.
- fetch_accept_i  in  1  decode consumes the instruction.

## Operation
- Registers:
  - pc_q[31:3]: next group address. Reset value BOOT_ADDR[31:3].
  - skip_q: the next group starts at its upper word. Reset value BOOT_ADDR[2].
  - pend_q: one request accepted and awaiting its response.
  - drop_q: discard the next response.
  - Each FIFO entry holds {inst[63:0], pc[31:3], start, fault}.
- Request issue:
  - icache_rd_o = !branch_request_i && !stall_q && (!pend_q || icache_valid_i) && (count + pend_q < FIFO_DEPTH).
  - icache_pc_o = {pc_q, 3'b0}.
  - Only one request is outstanding at a time.
  - icache_rd_o and icache_pc_o are held stable until icache_accept_i is asserted.
- On accept: pend_q <= 1; pc_q <= pc_q + 1, wrapping at 2^29; skip_q <= 0.
- On response: icache_valid_i clears pend_q unless a new accept occurs in the same cycle.
  - If drop_q = 1, the response is discarded and drop_q <= 0.
  - Otherwise the response is pushed with start = skip bit latched at issue, pc = issued pc.
- Output, taken from the FIFO head:
  - Word select w = word_q | head.start.
  - fetch_instr_o = head.inst[32*w +: 32].
  - fetch_pc_o = {head.pc, w, 2'b00}.
  - fetch_valid_o = !empty.
- Consume: when fetch_accept_i && fetch_valid_o:
  - If w = 0, word_q <= 1.
  - Otherwise the head is popped and word_q <= 0.
- Redirect: branch_request_i takes priority over every other event.
  - FIFO cleared, word_q <= 0, stall_q <= 0.
  - pc_q <= branch_pc_i[31:3]; skip_q <= branch_pc_i[2].
  - drop_q <= 1 if pend_q = 1 and icache_valid_i = 0 in that cycle; otherwise drop_q <= 0.
  - A response arriving in the redirect cycle is discarded.
- fence.i: icache_flush_o = fence_i_i registered, asserted for one cycle. Requests are suppressed while pend_q = 1 or icache_flush_o = 1.
- Simultaneous push and pop in the same cycle: count is unchanged.
- Reset values: icache_rd_o 0, icache_flush_o 0, fetch_valid_o 0, fetch_fault_o 0. FIFO empty, pend_q, drop_q and stall_q all 0.

## Timing
- icache_rd_o rises in the first cycle after reset release.
- Response to decode: a push in cycle N is visible as fetch_valid_o in cycle N+1, taken from the registered FIFO.
- Back-to-back hits sustain one 64-bit group per response. Each group takes two decode cycles, so the FIFO fills and throttles issue.
- Redirect in cycle N: fetch_valid_o = 0 in cycle N+1. The new request is issued no earlier than cycle N+1.
- Reset asserted mid-refill: all state clears immediately. A late icache_valid_i after reset with pend_q = 0 is ignored.

## Configuration
- IF_FETCH_FAULT_EN defined:
  - icache_error_i is stored in the entry's fault bit.
  - fetch_fault_o = head.fault && fetch_valid_o.
  - After pushing a faulting group, stall_q <= 1 and no further requests are issued until a redirect.
- IF_FETCH_FAULT_EN undefined:
  - icache_error_i is ignored.
  - fetch_fault_o is tied 0.
  - Fetch continues sequentially.

## Test plan
- Reset with BOOT_ADDR=0x80000000 and a cache that hits with 1-cycle latency -> icache_pc_o shows 0x80000000, then 0x80000008. Decode sees PCs 0x80000000, 0x80000004, 0x80000008 in order, with matching instruction words.
- Redirect to 0x80000104 -> next icache_pc_o = 0x80000100. The first fetch_pc_o is 0x80000104, with the instruction taken from icache_inst_i[63:32].
- Redirect while a refill is pending (response 12 cycles late) -> the late group is not delivered. The first delivered PC equals the target.
- Hold fetch_accept_i=0 with FIFO_DEPTH=4 -> exactly 4 groups are accepted, then icache_rd_o=0. Releasing fetch_accept_i resumes issue with no lost or duplicated PC.
- Pulse fence_i_i with a request pending -> icache_flush_o is high for exactly one cycle and no request is issued that cycle. Fetch resumes at the sequential PC.
- With IF_FETCH_FAULT_EN, icache_error_i=1 on the group at 0x80000010 -> fetch_fault_o=1 for PC 0x80000010. No icache_rd_o is asserted until a redirect.
